// File: rtl/shift_sched_pkg.sv
// shift_sched_pkg: shared state encoding and shifter pass limit for shift_sched
package shift_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int MAX_STEP = 3;
endpackage

// File: rtl/shift_sched_barrel_shifter.sv
// barrel_shifter: 4-bit combinational logical right shifter, 0..3 positions
module barrel_shifter (
  input  logic [3:0] a,
  input  logic [1:0] selector,
  output logic [3:0] y
);
  assign y = a >> selector;
endmodule

// File: rtl/shift_sched.sv
// shift_sched: round-robin sequencer recirculating words through one shared 0..3 shifter
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [3:0]       res_data,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy
);
  state_t           state, state_next;
  logic [3:0]       data_r, shifted;
  logic [AMT_W-1:0] rem_r, step, acc_amt;
  logic             owner_r, last_grant, acc0, acc1, acc;
  assign acc0 = state == IDLE && req0_valid && (!req1_valid || last_grant);
  assign acc1 = state == IDLE && req1_valid && (!req0_valid || !last_grant);
  assign acc = acc0 || acc1;
  assign acc_amt = acc1 ? req1_amt : req0_amt;
  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign step = (rem_r >= AMT_W'(MAX_STEP)) ? AMT_W'(MAX_STEP) : rem_r;
  barrel_shifter u_shift (.a(data_r), .selector(step[1:0]), .y(shifted));
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = !acc ? IDLE : (acc_amt != '0) ? RUN : DONE;
      RUN:     state_next = (rem_r == step) ? DONE : RUN;
      DONE:    state_next = res_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_r     <= '0;
      rem_r      <= '0;
      owner_r    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (acc) begin
        data_r     <= acc1 ? req1_data : req0_data;
        rem_r      <= acc_amt;
        owner_r    <= acc1;
        last_grant <= acc1;
      end else if (state == RUN) begin
        data_r <= shifted;
        rem_r  <= rem_r - step;
      end
    end
  end
  assign res_valid = state == DONE;
  assign res_data  = res_valid ? data_r : 4'd0;
  assign res_id    = res_valid & owner_r;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed scenario tests for shift_sched
module tb_shift_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_data, req1_data, res_data;
  logic [2:0] req0_amt, req1_amt;
  logic res_valid, res_id, res_ready, busy;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_sched #(.AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    req0_data = 0; req1_data = 0; req0_amt = 0; req1_amt = 0;
    tick(); tick();
    total++;
    if ({res_valid, res_data, res_id, busy} !== 7'd0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", {res_valid, res_data, res_id, busy}, 7'd0);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({busy, res_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_idle got=%b exp=00", {busy, res_valid});
    end
  endtask

  task automatic test_basic();
    req0_valid = 1; req0_data = 4'b1011; req0_amt = 3'd2; res_ready = 1;
    #1;
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL basic_ready got=%b exp=1", req0_ready);
    end
    tick();
    req0_valid = 0;
    total++;
    if ({busy, res_valid} !== 2'b10) begin
      bad++; $display("FAIL basic_run got=%b exp=10", {busy, res_valid});
    end
    tick();
    total++;
    if ({res_valid, res_data, res_id} !== {1'b1, 4'b0010, 1'b0}) begin
      bad++; $display("FAIL basic_result got=%b exp=%b", {res_valid, res_data, res_id}, {1'b1, 4'b0010, 1'b0});
    end
    tick();
    total++;
    if ({busy, res_valid} !== 2'b00) begin
      bad++; $display("FAIL basic_release got=%b exp=00", {busy, res_valid});
    end
  endtask

  task automatic test_amt7();
    req1_valid = 1; req1_data = 4'b1111; req1_amt = 3'd7; res_ready = 0;
    tick();
    req1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({busy, res_valid} !== 2'b10) begin
        bad++; $display("FAIL amt7_pass%0d got=%b exp=10", i, {busy, res_valid});
      end
      tick();
    end
    total++;
    if ({busy, res_valid, res_data, res_id} !== {1'b1, 1'b1, 4'b0000, 1'b1}) begin
      bad++; $display("FAIL amt7_result got=%b exp=%b", {busy, res_valid, res_data, res_id}, {1'b1, 1'b1, 4'b0000, 1'b1});
    end
    res_ready = 1;
    tick();
  endtask

  task automatic test_alternate();
    rst_n = 0;
    tick();
    rst_n = 1;
    req0_valid = 1; req0_data = 4'b1000; req0_amt = 3'd1;
    req1_valid = 1; req1_data = 4'b0100; req1_amt = 3'd1;
    res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
      exp_id = i[0];
      #1;
      total++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        bad++; $display("FAIL alt_grant%0d got=%b exp=%b", i, {req0_ready, req1_ready}, {~exp_id, exp_id});
      end
      tick();
      total++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        bad++; $display("FAIL alt_run_ready%0d got=%b exp=00", i, {req0_ready, req1_ready});
      end
      tick();
      total++;
      if ({res_valid, res_id, res_data, req0_ready, req1_ready} !== {1'b1, exp_id, exp_id ? 4'b0010 : 4'b0100, 2'b00}) begin
        bad++; $display("FAIL alt_result%0d got=%b exp=%b", i, {res_valid, res_id, res_data, req0_ready, req1_ready},
                        {1'b1, exp_id, exp_id ? 4'b0010 : 4'b0100, 2'b00});
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_hold();
    req0_valid = 1; req0_data = 4'b0110; req0_amt = 3'd0; res_ready = 0;
    tick();
    req0_valid = 0; req1_valid = 1; req1_amt = 3'd1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({res_valid, res_data, res_id, req0_ready, req1_ready} !== {1'b1, 4'b0110, 1'b0, 2'b00}) begin
        bad++; $display("FAIL hold%0d got=%b exp=%b", i, {res_valid, res_data, res_id, req0_ready, req1_ready}, {1'b1, 4'b0110, 1'b0, 2'b00});
      end
      tick();
    end
    req1_valid = 0; res_ready = 1;
    tick();
    total++;
    if ({busy, res_valid} !== 2'b00) begin
      bad++; $display("FAIL hold_release got=%b exp=00", {busy, res_valid});
    end
  endtask

  task automatic test_reset_mid();
    req1_valid = 1; req1_data = 4'b1111; req1_amt = 3'd7; res_ready = 1;
    tick();
    req1_valid = 0;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    total++;
    if ({res_valid, res_data, res_id, busy} !== 7'd0) begin
      bad++; $display("FAIL midrst_outputs got=%b exp=%b", {res_valid, res_data, res_id, busy}, 7'd0);
    end
    req0_valid = 1; req0_data = 4'b0101; req0_amt = 3'd0;
    req1_valid = 1; req1_data = 4'b1010; req1_amt = 3'd0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL midrst_grant got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    total++;
    if ({res_valid, res_data, res_id} !== {1'b1, 4'b0101, 1'b0}) begin
      bad++; $display("FAIL midrst_result got=%b exp=%b", {res_valid, res_data, res_id}, {1'b1, 4'b0101, 1'b0});
    end
    tick();
  endtask

  task automatic test_step3();
    req0_valid = 1; req0_data = 4'b1000; req0_amt = 3'd3; res_ready = 1;
    tick();
    req0_valid = 0;
    tick();
    total++;
    if ({res_valid, res_data} !== {1'b1, 4'b0001}) begin
      bad++; $display("FAIL step3_result got=%b exp=%b", {res_valid, res_data}, {1'b1, 4'b0001});
    end
    tick();
    req0_valid = 1; req0_data = 4'b1111; req0_amt = 3'd6;
    tick();
    req0_valid = 0;
    tick();
    total++;
    if (res_valid !== 1'b0) begin
      bad++; $display("FAIL amt6_early got=%b exp=0", res_valid);
    end
    tick();
    total++;
    if ({res_valid, res_data, res_id} !== {1'b1, 4'b0000, 1'b0}) begin
      bad++; $display("FAIL amt6_result got=%b exp=%b", {res_valid, res_data, res_id}, {1'b1, 4'b0000, 1'b0});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_amt7();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_step3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
